// File: rtl/pb_event_sched.sv
// Push-button event scheduler: synchronizes and debounces active-low buttons,
// runs a press/hold/release FSM per button, and arbitrates the resulting events
// round-robin into a small first-word-fall-through FIFO with valid/ready output.
module pb_event_sched #(
   parameter int NUM_PB       = 4,
   parameter int DEBOUNCE_CYC = 16,
   parameter int LONG_CYC     = 1024,
   parameter int FIFO_DEPTH   = 4,
   localparam int IDW         = $clog2(NUM_PB)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NUM_PB-1:0] pb,
   output logic           evt_valid,
   input  logic           evt_ready,
   output logic [IDW-1:0] evt_id,
   output logic [1:0]     evt_type,
   output logic           overflow,
   input  logic           ovf_clr
);

   localparam int CW   = $clog2(DEBOUNCE_CYC);
   localparam int HW   = $clog2(LONG_CYC);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;

   localparam logic [1:0] EV_PRESS    = 2'b00;
   localparam logic [1:0] EV_RELEASE  = 2'b01;
   localparam logic [1:0] EV_LONG     = 2'b10;
   localparam logic [1:0] EV_LONG_REL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   logic [NUM_PB-1:0] sync1, sync2, stable;
   logic [CW-1:0]     db_cnt [NUM_PB];

   state_t            state     [NUM_PB];
   state_t            state_nxt [NUM_PB];
   logic [HW-1:0]     hold      [NUM_PB];
   logic [HW-1:0]     hold_nxt  [NUM_PB];
   logic [NUM_PB-1:0] emit;
   logic [1:0]        emit_type [NUM_PB];

   logic [NUM_PB-1:0] slot_valid;
   logic [1:0]        slot_type [NUM_PB];
   logic [NUM_PB-1:0] drained, drop;
   logic [IDW-1:0]    rr_ptr;
   logic              grant_valid;
   logic [IDW-1:0]    grant;

   logic [IDW-1:0]    mem_id   [FIFO_DEPTH];
   logic [1:0]        mem_type [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, head_ptr;
   logic [CNTW-1:0]   count;
   logic              fifo_full, push, pop;

   // Two-flop synchronizer plus per-button debounce counter.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '1;
         sync2  <= '1;
         stable <= '1;
         for (int i = 0; i < NUM_PB; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= pb;
         sync2 <= sync1;
         for (int i = 0; i < NUM_PB; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + CW'(1);
            end
         end
      end
   end

   // Per-button FSM state and hold-time registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PB; i++) begin
            state[i] <= ST_IDLE;
            hold[i]  <= '0;
         end
      end else begin
         state <= state_nxt;
         hold  <= hold_nxt;
      end
   end

   // Per-button next state and event emission; release wins over long-hold.
   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      emit = '0;
      for (int i = 0; i < NUM_PB; i++) begin
         state_nxt[i] = state[i];
         hold_nxt[i]  = hold[i];
         emit_type[i] = EV_PRESS;
         case (state[i])
            ST_IDLE: begin
               if (!stable[i]) begin
                  state_nxt[i] = ST_PRESSED;
                  hold_nxt[i]  = '0;
                  emit[i]      = 1'b1;
                  emit_type[i] = EV_PRESS;
               end
            end
            ST_PRESSED: begin
               if (stable[i]) begin
                  state_nxt[i] = ST_IDLE;
                  emit[i]      = 1'b1;
                  emit_type[i] = EV_RELEASE;
               end else if (hold[i] == HW'(LONG_CYC - 1)) begin
                  state_nxt[i] = ST_HELD;
                  emit[i]      = 1'b1;
                  emit_type[i] = EV_LONG;
               end else begin
                  hold_nxt[i] = hold[i] + HW'(1);
               end
            end
            ST_HELD: begin
               if (stable[i]) begin
                  state_nxt[i] = ST_IDLE;
                  emit[i]      = 1'b1;
                  emit_type[i] = EV_LONG_REL;
               end
            end
            default: state_nxt[i] = ST_IDLE;
         endcase
      end
   end

   // Round-robin grant of the first occupied slot at or above the pointer.
   always_comb begin
      int            sum;
      logic [IDW-1:0] idx;
      sum         = 0;
      idx         = '0;
      grant_valid = 1'b0;
      grant       = '0;
      drained     = '0;
      for (int k = 0; k < NUM_PB; k++) begin
         sum = int'(rr_ptr) + k;
         if (sum >= NUM_PB) sum = sum - NUM_PB;
         idx = IDW'(sum);
         if (!grant_valid && !fifo_full && slot_valid[idx]) begin
            grant_valid = 1'b1;
            grant       = idx;
         end
      end
      for (int i = 0; i < NUM_PB; i++) begin
         drained[i] = grant_valid && (grant == IDW'(i));
      end
      drop = emit & slot_valid & ~drained;
   end

   // Pending slots, round-robin pointer and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= '0;
         for (int i = 0; i < NUM_PB; i++) slot_type[i] <= EV_PRESS;
         rr_ptr     <= '0;
         overflow   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_PB; i++) begin
            if (emit[i] && (!slot_valid[i] || drained[i])) begin
               slot_valid[i] <= 1'b1;
               slot_type[i]  <= emit_type[i];
            end else if (drained[i]) begin
               slot_valid[i] <= 1'b0;
            end
         end
         if (grant_valid) begin
            rr_ptr <= (grant == IDW'(NUM_PB - 1)) ? '0 : grant + IDW'(1);
         end
         if (|drop) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   assign fifo_full = (count == CNTW'(FIFO_DEPTH));
   assign evt_valid = (count != '0);
   assign push      = grant_valid;
   assign pop       = evt_valid && evt_ready;

   // Event FIFO storage, pointers and occupancy.
   // NOTE: the storage is reset so an empty FIFO presents zeros through the held-head view after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_id[i]   <= '0;
            mem_type[i] <= EV_PRESS;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_id[wr_ptr]   <= grant;
            mem_type[wr_ptr] <= slot_type[grant];
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase
      end
   end

   // When empty the last popped entry (one behind the read pointer) stays visible.
   assign head_ptr = evt_valid ? rd_ptr : rd_ptr - AW'(1);
   assign evt_id   = mem_id[head_ptr];
   assign evt_type = mem_type[head_ptr];

endmodule

// File: tb/tb_pb_event_sched.sv
// Self-checking bench for pb_event_sched: directed scenarios followed by random
// button/ready traffic, all compared every cycle against an event-level model.
module tb_pb_event_sched;

   localparam int N     = 4;
   localparam int D     = 4;
   localparam int L     = 32;
   localparam int DEPTH = 4;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] pb;
   logic         evt_valid;
   logic         evt_ready;
   logic [1:0]   evt_id;
   logic [1:0]   evt_type;
   logic         overflow;
   logic         ovf_clr;

   int compared   = 0;
   int mismatched = 0;
   int tcyc       = 0;
   int log_t[$];
   int log_e[$];

   // reference model state
   int           m_cyc;
   logic [N-1:0] m_p1, m_p2, m_level;
   int           m_run[N];
   bit           m_pressed[N];
   bit           m_long[N];
   int           m_tpress[N];
   int           m_slot[N];
   int           m_q[$];
   int           m_rr;
   bit           m_ovf;
   int           m_last;

   pb_event_sched #(
      .NUM_PB(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pb(pb),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_id(evt_id), .evt_type(evt_type),
      .overflow(overflow), .ovf_clr(ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_p1 = '1; m_p2 = '1; m_level = '1;
      for (int i = 0; i < N; i++) begin
         m_run[i] = 0; m_pressed[i] = 0; m_long[i] = 0; m_tpress[i] = 0; m_slot[i] = -1;
      end
      m_q.delete();
      m_rr = 0; m_ovf = 0; m_last = 0; m_cyc = 0;
   endfunction

   // One clock edge of the event-level behaviour, using pre-edge values throughout.
   function automatic void model_step();
      int g, gtype, idx;
      int em[N];
      bit pop, ovf_set;
      m_cyc++;
      pop = (m_q.size() > 0) && evt_ready;
      g = -1;
      if (m_q.size() < DEPTH) begin
         for (int k = 0; k < N; k++) begin
            idx = (m_rr + k) % N;
            if (g < 0 && m_slot[idx] >= 0) g = idx;
         end
      end
      gtype = (g >= 0) ? m_slot[g] : 0;
      // events from the debounced level and the time since the press
      for (int i = 0; i < N; i++) begin
         em[i] = -1;
         if (!m_pressed[i]) begin
            if (m_level[i] == 1'b0) begin
               em[i] = 0; m_pressed[i] = 1; m_long[i] = 0; m_tpress[i] = m_cyc;
            end
         end else if (m_level[i] == 1'b1) begin
            em[i] = m_long[i] ? 3 : 1;
            m_pressed[i] = 0;
         end else if (!m_long[i] && (m_cyc - m_tpress[i] == L)) begin
            em[i] = 2; m_long[i] = 1;
         end
      end
      ovf_set = 0;
      for (int i = 0; i < N; i++) begin
         if (em[i] >= 0) begin
            if (m_slot[i] >= 0 && g != i) ovf_set = 1;
            else m_slot[i] = em[i];
         end else if (g == i) begin
            m_slot[i] = -1;
         end
      end
      if (pop) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back(g * 4 + gtype);
         m_rr = (g + 1) % N;
      end
      if (ovf_set) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      // accept a new level after D consecutive differing samples
      for (int i = 0; i < N; i++) begin
         if (m_p2[i] == m_level[i]) begin
            m_run[i] = 0;
         end else begin
            m_run[i]++;
            if (m_run[i] == D) begin
               m_level[i] = m_p2[i];
               m_run[i] = 0;
            end
         end
      end
      m_p2 = m_p1;
      m_p1 = pb;
      if (m_q.size() > 0) m_last = m_q[0];
   endfunction

   // Advance one clock, log any accepted entry, then compare against the model.
   task automatic cycle();
      if (evt_valid && evt_ready) begin
         log_t.push_back(tcyc);
         log_e.push_back(int'(evt_id) * 4 + int'(evt_type));
      end
      @(posedge clk);
      tcyc++;
      model_step();
      @(negedge clk);
      check("evt_valid", evt_valid, (m_q.size() > 0) ? 32'd1 : 32'd0);
      check("evt_id", evt_id, 32'(m_last >> 2));
      check("evt_type", evt_type, 32'(m_last & 3));
      check("overflow", overflow, m_ovf ? 32'd1 : 32'd0);
   endtask

   // Called at a falling edge: asynchronous assert, immediate output check, release.
   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_valid"}, evt_valid, 0);
      check({tag, "_id"}, evt_id, 0);
      check({tag, "_type"}, evt_type, 0);
      check({tag, "_ovf"}, overflow, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic wait_valid(input int bound, output int n);
      n = 0;
      while (!evt_valid && n < bound) begin
         cycle();
         n++;
      end
   endtask

   initial begin
      int n;
      int vcount;
      rst_n = 1'b0; pb = '1; evt_ready = 1'b0; ovf_clr = 1'b0;
      do_reset("por");

      // single press and release of button 0
      evt_ready = 1'b1;
      pb[0] = 1'b0;
      wait_valid(40, n);
      check("press_latency", n, D + 4);
      check("press_id", evt_id, 0);
      check("press_type", evt_type, 0);
      repeat (10) cycle();
      pb[0] = 1'b1;
      wait_valid(40, n);
      check("release_latency", n, D + 4);
      check("release_id", evt_id, 0);
      check("release_type", evt_type, 1);
      repeat (5) cycle();

      // bouncing button 1, then a clean low level
      vcount = 0;
      for (int k = 0; k < 10; k++) begin
         pb[1] = ~pb[1];
         repeat (2) begin
            cycle();
            if (evt_valid) vcount++;
         end
      end
      check("bounce_quiet", vcount, 0);
      pb[1] = 1'b0;
      wait_valid(40, n);
      check("bounce_latency", n, D + 4);
      check("bounce_id", evt_id, 1);
      check("bounce_type", evt_type, 0);
      pb[1] = 1'b1;
      repeat (15) cycle();

      // long hold of button 2
      log_t.delete(); log_e.delete();
      pb[2] = 1'b0;
      repeat (60) cycle();
      pb[2] = 1'b1;
      repeat (20) cycle();
      check("long_count", log_e.size(), 3);
      if (log_e.size() == 3) begin
         check("long_ev0", log_e[0], 2 * 4 + 0);
         check("long_ev1", log_e[1], 2 * 4 + 2);
         check("long_ev2", log_e[2], 2 * 4 + 3);
         check("long_gap", log_t[1] - log_t[0], L);
      end

      // all four buttons at once from a freshly reset pointer
      do_reset("rst2");
      evt_ready = 1'b0;
      pb = '0;
      repeat (12) cycle();
      check("simul_queued", evt_valid, 1);
      log_t.delete(); log_e.delete();
      evt_ready = 1'b1;
      repeat (4) cycle();
      evt_ready = 1'b0;
      pb = '1;
      check("simul_count", log_e.size(), 4);
      if (log_e.size() == 4) begin
         for (int i = 0; i < 4; i++) check("simul_order", log_e[i], i * 4);
      end

      // overflow: FIFO filled by releases, then press and release of button 0
      repeat (12) cycle();
      pb[0] = 1'b0;
      repeat (10) cycle();
      pb[0] = 1'b1;
      repeat (10) cycle();
      check("ovf_set", overflow, 1);
      ovf_clr = 1'b1;
      cycle();
      ovf_clr = 1'b0;
      check("ovf_clear", overflow, 0);
      pb[0] = 1'b0;
      repeat (6) cycle();
      check("ovf_pre_drop", overflow, 0);
      ovf_clr = 1'b1;
      cycle();
      ovf_clr = 1'b0;
      check("ovf_set_wins", overflow, 1);

      // reset with two entries queued; button 0 stays held through it
      evt_ready = 1'b1;
      repeat (3) cycle();
      evt_ready = 1'b0;
      check("two_queued", evt_valid, 1);
      pb = 4'b1010;
      do_reset("midrst");
      repeat (12) cycle();
      check("ptr_restart_valid", evt_valid, 1);
      check("ptr_restart_id", evt_id, 0);

      // random traffic: relaxed consumer first, then a slow one to force drops
      for (int c = 0; c < 1600; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 17) == 0) pb[i] = ~pb[i];
         end
         evt_ready = (c < 800) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
         ovf_clr = ($urandom_range(0, 39) == 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
